// File: rtl/pipe_pkg.sv
// Shared encodings for the RV32I pipeline: control-bundle layout, operand-B select,
// opcodes and the source-register usage rules applied by ID-stage hazard checks.
package pipe_pkg;

    localparam int unsigned CTRL_W     = 11;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned OPC_W      = 7;
    localparam int unsigned ALU_CTRL_W = 4;

    // Bit positions inside the packed control bundle
    localparam int unsigned CTRL_IS_JAL       = 10;
    localparam int unsigned CTRL_IS_JALR      = 9;
    localparam int unsigned CTRL_BRANCH       = 8;
    localparam int unsigned CTRL_MEM_READ     = 7;
    localparam int unsigned CTRL_MEM_TO_REG   = 6;
    localparam int unsigned CTRL_MEM_WRITE    = 5;
    localparam int unsigned CTRL_ALU_SRC_B_HI = 4;
    localparam int unsigned CTRL_ALU_SRC_B_LO = 3;
    localparam int unsigned CTRL_WRITE_ENABLE = 2;
    localparam int unsigned CTRL_PC_TO_REG    = 1;
    localparam int unsigned CTRL_IS_ECALL     = 0;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_PC4  = 2'b10,
        SRCB_NONE = 2'b11
    } src_b_e;

    typedef struct packed {
        logic   is_jal;
        logic   is_jalr;
        logic   branch;
        logic   mem_read;
        logic   mem_to_reg;
        logic   mem_write;
        src_b_e alu_src_b;
        logic   write_enable;
        logic   pc_to_reg;
        logic   is_ecall;
    } ctrl_t;

    // A bubble does nothing and selects no operand B
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'({SRCB_NONE, 3'b000});

    localparam logic [REG_W-1:0] ECALL_REG = REG_W'(17);

    localparam logic [OPC_W-1:0] OPC_LUI        = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL        = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR       = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD       = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE      = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_ARITH_IMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_ARITHMETIC = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_ECALL      = 7'b1110011;

    // Every known opcode except JAL and ECALL is treated as an rs1 reader
    function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_ARITH_IMM, OPC_ARITHMETIC: uses_rs1 = 1'b1;
            default:                                  uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_ARITHMETIC, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
            default:                               uses_rs2 = 1'b0;
        endcase
    endfunction

    // ECALL reads the syscall number from x17 without naming it in rs1/rs2
    function automatic logic uses_x17(input logic [OPC_W-1:0] opc);
        uses_x17 = (opc == OPC_ECALL);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational ID-stage hazard check against the instructions in EX and MEM.
// FORWARDING_EN: defined = only load-use and ecall hazards; undefined = stall on any RAW with EX/MEM.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_write_enable,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_write_enable,
    output logic             hazard
);

    logic use_rs1;
    logic use_rs2;
    logic use_x17;
    logic ex_src_match;
    logic ex_writes;
    logic load_use;
    logic ecall_hazard;
    logic raw_hazard;

    assign use_rs1   = uses_rs1(id_opcode);
    assign use_rs2   = uses_rs2(id_opcode);
    assign use_x17   = uses_x17(id_opcode);
    assign ex_writes = ex_valid && ex_write_enable;

    // x0 is hardwired, so a zero destination never matches
    assign ex_src_match = (ex_rd != '0)
                        && ((use_rs1 && (id_rs1 == ex_rd))
                         || (use_rs2 && (id_rs2 == ex_rd))
                         || (use_x17 && (ex_rd == ECALL_REG)));

    assign load_use = ex_valid && ex_mem_read && ex_src_match;

    assign ecall_hazard = use_x17
                        && ((ex_writes && (ex_rd == ECALL_REG))
                         || (mem_write_enable && (mem_rd == ECALL_REG)));

`ifdef FORWARDING_EN
    assign raw_hazard = 1'b0;
`else
    logic mem_src_match;

    assign mem_src_match = (mem_rd != '0)
                         && ((use_rs1 && (id_rs1 == mem_rd))
                          || (use_rs2 && (id_rs2 == mem_rd))
                          || (use_x17 && (mem_rd == ECALL_REG)));

    // Register file writes through, so WB never needs a stall
    assign raw_hazard = (ex_writes && ex_src_match)
                      || (mem_write_enable && mem_src_match);
`endif

    assign hazard = id_valid && (load_use || ecall_hazard || raw_hazard);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / ecall stall generation, flush squash
// and a saturating stall counter. Hazard rules depend on FORWARDING_EN (see hazard_detect).
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [OPC_W-1:0]      id_opcode,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic [REG_W-1:0]      id_rd,
    input  logic [REG_W-1:0]      mem_rd,
    input  logic                  mem_write_enable,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic [REG_W-1:0]      ex_rs1,
    output logic [REG_W-1:0]      ex_rs2,
    output logic [REG_W-1:0]      ex_rd,
    output logic [CNT_W-1:0]      stall_count
);

    ctrl_t ex_ctrl_q;
    logic  hazard;

    hazard_detect u_hazard_detect (
        .id_valid         (id_valid),
        .id_opcode        (id_opcode),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .ex_valid         (ex_valid),
        .ex_mem_read      (ex_ctrl_q.mem_read),
        .ex_write_enable  (ex_ctrl_q.write_enable),
        .ex_rd            (ex_rd),
        .mem_rd           (mem_rd),
        .mem_write_enable (mem_write_enable),
        .hazard           (hazard)
    );

    // A flush redirects fetch, so holding IF/ID would lose the new target
    assign stall   = hazard && !flush;
    assign ex_ctrl = ex_ctrl_q;

    // Data fields always follow ID; only valid/ctrl decide whether EX does anything
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl_q   <= ctrl_t'(BUBBLE_CTRL);
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_alu_ctrl <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_alu_ctrl <= id_alu_ctrl;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            if (flush || hazard || !id_valid) begin
                ex_valid  <= 1'b0;
                ex_ctrl_q <= ctrl_t'(BUBBLE_CTRL);
            end else begin
                ex_valid  <= 1'b1;
                ex_ctrl_q <= ctrl_t'(id_ctrl);
            end
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized
// instruction streams checked against a behavioural pipeline model.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned SAT_W = 3;
    localparam int unsigned SAT_MAX = 7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // {jal,jalr,branch,mem_read,mem_to_reg,mem_write,srcB[1:0],we,pc_to_reg,ecall}
    localparam logic [10:0] BUBBLE = 11'b000_000_11_000;
    localparam int MEM_READ_BIT = 7;
    localparam int WE_BIT       = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [10:0]      id_ctrl;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]       id_alu_ctrl;
    logic [4:0]       id_rs1, id_rs2, id_rd, mem_rd;
    logic             mem_write_enable, flush;

    logic             stall, ex_valid;
    logic [10:0]      ex_ctrl;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0]       ex_alu_ctrl;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [CNT_W-1:0] stall_count;

    logic             s_stall, s_ex_valid;
    logic [10:0]      s_ex_ctrl;
    logic [XLEN-1:0]  s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [3:0]       s_ex_alu_ctrl;
    logic [4:0]       s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [SAT_W-1:0] s_stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the EX stage, the downstream MEM stage and the counters
    logic            m_valid;
    logic [10:0]     m_ctrl;
    logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [3:0]      m_alu;
    logic [4:0]      m_rs1, m_rs2, m_rd, m_mem_rd;
    logic            m_mem_we;
    longint unsigned m_cnt;
    int unsigned     m_sat;
    bit              m_stall, m_haz, m_was_reset;
    logic            obs_stall;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .mem_rd(mem_rd), .mem_write_enable(mem_write_enable), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .stall_count(stall_count)
    );

    id_ex_stage #(.XLEN(XLEN), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .mem_rd(mem_rd), .mem_write_enable(mem_write_enable), .flush(flush),
        .stall(s_stall), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_pc(s_ex_pc),
        .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
        .ex_alu_ctrl(s_ex_alu_ctrl), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] ctrl_for(input logic [6:0] op);
        case (op)
            OP_LOAD:                 ctrl_for = 11'b000_110_01_100;
            OP_STORE:                ctrl_for = 11'b000_001_01_000;
            OP_BRANCH:               ctrl_for = 11'b001_000_00_000;
            OP_REG:                  ctrl_for = 11'b000_000_00_100;
            OP_IMM, OP_LUI, OP_AUIPC: ctrl_for = 11'b000_000_01_100;
            OP_JAL:                  ctrl_for = 11'b100_000_10_110;
            OP_JALR:                 ctrl_for = 11'b010_000_01_110;
            OP_SYS:                  ctrl_for = 11'b000_000_11_001;
            default:                 ctrl_for = BUBBLE;
        endcase
    endfunction

    // Hazard from the rules: list the registers ID reads, then look for producers downstream
    function automatic bit model_hazard();
        logic [4:0] srcs[$];
        bit h = 1'b0;
        bit ex_writes = m_valid && m_ctrl[WE_BIT];
        bit ex_load   = m_valid && m_ctrl[MEM_READ_BIT];
        if (id_opcode inside {OP_LUI, OP_AUIPC, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG})
            srcs.push_back(id_rs1);
        if (id_opcode inside {OP_REG, OP_STORE, OP_BRANCH})
            srcs.push_back(id_rs2);
        if (id_opcode == OP_SYS)
            srcs.push_back(5'd17);
        foreach (srcs[i]) begin
            if (srcs[i] != 5'd0) begin
                if (ex_load && srcs[i] == m_rd) h = 1'b1;
`ifndef FORWARDING_EN
                if (ex_writes && srcs[i] == m_rd) h = 1'b1;
                if (m_mem_we && srcs[i] == m_mem_rd) h = 1'b1;
`endif
            end
        end
        if (id_opcode == OP_SYS && ((ex_writes && m_rd == 5'd17) || (m_mem_we && m_mem_rd == 5'd17)))
            h = 1'b1;
        return id_valid && h;
    endfunction

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        id_valid    = 1'b1;
        id_opcode   = op;
        id_ctrl     = ctrl_for(op);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_alu_ctrl = 4'($urandom);
    endtask

    // One clock: check stall mid-cycle, advance the model, check EX after the edge
    task automatic tick();
        logic            n_valid;
        logic [10:0]     n_ctrl;
        logic [4:0]      n_mem_rd;
        logic            n_mem_we;
        longint unsigned n_cnt;
        int unsigned     n_sat;
        mem_rd           = m_mem_rd;
        mem_write_enable = m_mem_we;
        @(negedge clk);
        m_haz     = model_hazard();
        m_stall   = m_haz && !flush;
        obs_stall = stall;
        check("stall", stall, 64'(m_stall));
        if (reset) begin
            n_valid = 1'b0; n_ctrl = BUBBLE; n_mem_rd = '0; n_mem_we = 1'b0;
            n_cnt = 0; n_sat = 0;
        end else begin
            n_cnt    = (m_stall && m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
            n_sat    = (m_stall && m_sat < SAT_MAX) ? m_sat + 1 : m_sat;
            n_valid  = id_valid && !flush && !m_haz;
            n_ctrl   = n_valid ? id_ctrl : BUBBLE;
            n_mem_rd = m_rd;
            n_mem_we = m_valid && m_ctrl[WE_BIT];
        end
        @(posedge clk);
        #1;
        m_was_reset = reset;
        m_mem_rd = n_mem_rd;
        m_mem_we = n_mem_we;
        m_valid  = n_valid;
        m_ctrl   = n_ctrl;
        m_cnt    = n_cnt;
        m_sat    = n_sat;
        if (reset) begin
            m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0; m_alu = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        end else begin
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_alu = id_alu_ctrl; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
        end
        check("ex_valid", ex_valid, 64'(m_valid));
        check("ex_ctrl", ex_ctrl, 64'(m_ctrl));
        check("stall_count", stall_count, m_cnt);
        check("stall_count_sat", s_stall_count, 64'(m_sat));
        if (m_valid || m_was_reset) begin
            check("ex_pc", ex_pc, 64'(m_pc));
            check("ex_rs1_data", ex_rs1_data, 64'(m_rs1d));
            check("ex_rs2_data", ex_rs2_data, 64'(m_rs2d));
            check("ex_imm", ex_imm, 64'(m_imm));
            check("ex_alu_ctrl", ex_alu_ctrl, 64'(m_alu));
            check("ex_rs1", ex_rs1, 64'(m_rs1));
            check("ex_rs2", ex_rs2, 64'(m_rs2));
            check("ex_rd", ex_rd, 64'(m_rd));
        end
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [6:0] op_tab [11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                OP_STORE, OP_IMM, OP_REG, OP_SYS, OP_BAD};
    logic [4:0] reg_tab [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd17};

    initial begin
        longint unsigned c0;
        int n;
        reset = 1'b1; flush = 1'b0;
        mem_rd = '0; mem_write_enable = 1'b0;
        m_valid = 1'b0; m_ctrl = BUBBLE; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
        m_alu = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_mem_rd = '0; m_mem_we = 1'b0;
        m_cnt = 0; m_sat = 0; m_stall = 1'b0; m_haz = 1'b0; m_was_reset = 1'b0;
        set_id(OP_REG, 5'd1, 5'd2, 5'd3);

        // Reset held two cycles with a live instruction in ID
        tick(); tick();
        check("rst_valid", ex_valid, 0);
        check("rst_srcb", ex_ctrl[4:3], 2'b11);
        check("rst_ctrl", ex_ctrl, BUBBLE);
        check("rst_cnt", stall_count, 0);
        reset = 1'b0;

        // Load-use: lw x5 then add x6,x5,x7
        idle(2);
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5); tick();
        set_id(OP_REG, 5'd5, 5'd7, 5'd6); tick();
        check("lu_stall", obs_stall, 1);
        check("lu_bubble", ex_valid, 0);
        n = 0;
        while (m_stall && n < 4) begin tick(); n++; end
        check("lu_release", obs_stall, 0);
        check("lu_rd", ex_rd, 6);
        check("lu_valid", ex_valid, 1);
`ifdef FORWARDING_EN
        check("lu_cnt", stall_count, 1);
`else
        check("lu_cnt", stall_count, 2);
`endif

        // Load to x0 never stalls
        idle(2);
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd0); tick();
        set_id(OP_REG, 5'd0, 5'd0, 5'd1); tick();
        check("x0_stall", obs_stall, 0);
        check("x0_valid", ex_valid, 1);
        check("x0_rd", ex_rd, 1);

        // Flush and load-use together: bubble, no stall, counter frozen
        idle(2);
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5); tick();
        set_id(OP_REG, 5'd5, 5'd7, 5'd6);
        flush = 1'b1; c0 = stall_count;
        tick();
        flush = 1'b0;
        check("fl_stall", obs_stall, 0);
        check("fl_valid", ex_valid, 0);
        check("fl_cnt", stall_count, c0);

        // Ecall waits for an x17 writer in EX and then in MEM
        idle(2);
        set_id(OP_IMM, 5'd0, 5'd0, 5'd17); tick();
        set_id(OP_SYS, 5'd0, 5'd0, 5'd0); tick();
        check("ec_stall_ex", obs_stall, 1);
        tick();
        check("ec_stall_mem", obs_stall, 1);
        tick();
        check("ec_go", obs_stall, 0);
        check("ec_latched", ex_ctrl[0], 1);
        check("ec_valid", ex_valid, 1);

        // Plain ALU RAW: stalls only without forwarding
        idle(2);
        set_id(OP_REG, 5'd1, 5'd2, 5'd3); tick();
        set_id(OP_REG, 5'd3, 5'd1, 5'd4); tick();
`ifdef FORWARDING_EN
        check("raw_stall", obs_stall, 0);
`else
        check("raw_stall", obs_stall, 1);
`endif

        // Reset in the middle of a load-use stall
        idle(2);
        set_id(OP_LOAD, 5'd1, 5'd0, 5'd5); tick();
        set_id(OP_REG, 5'd5, 5'd7, 5'd6);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rm_stall", obs_stall, 1);
        check("rm_valid", ex_valid, 0);
        check("rm_cnt", stall_count, 0);
        tick();
        check("rm_nostall", obs_stall, 0);
        check("rm_rd", ex_rd, 6);

        // Randomized stream; a stalled instruction stays in ID
        for (int i = 0; i < 1500; i++) begin
            if (!m_stall) begin
                if ($urandom_range(0, 9) < 8)
                    set_id(op_tab[$urandom_range(0, 10)], reg_tab[$urandom_range(0, 5)],
                           reg_tab[$urandom_range(0, 5)], reg_tab[$urandom_range(0, 5)]);
                else
                    id_valid = 1'b0;
            end
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        flush = 1'b0; reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RV32I core, including load-use and ecall hazard detection. It consumes the decoder's control bundle and register-file reads in ID and registers them for EX. It drives the stall signal back to the PC and IF/ID. It also applies flushes requested by EX on taken branches and jumps.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  opcode of ID instruction (opcodes.v encodings)
id_ctrl  in  11  packed {is_jal,is_jalr,branch,mem_read,mem_to_reg,mem_write,alu_src_B[1:0],write_enable,pc_to_reg,is_ecall}
id_pc  in  XLEN  PC of ID instruction
id_rs1_data  in  XLEN  register file read port 1
id_rs2_data  in  XLEN  register file read port 2
id_imm  in  XLEN  sign-extended immediate
id_alu_ctrl  in  4  {funct7[5],funct3}
id_rs1  in  5  source index 1
id_rs2  in  5  source index 2
id_rd  in  5  destination index
mem_rd  in  5  rd of EX/MEM stage
mem_write_enable  in  1  EX/MEM stage writes rd
flush  in  1  EX resolved taken branch/jump; squash ID
stall  out  1  combinational; hold PC and IF/ID
ex_valid  out  1  registered valid
ex_ctrl  out  11  registered control bundle
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered data
ex_alu_ctrl  out  4  registered
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (sync): all outputs 0, except ex_ctrl alu_src_B = 2'b11 (none) and stall_count = 0.
- Latency: ID values appear on ex_* one clk edge later.
- Source use: rs1 is used by all opcodes except JAL, ECALL and unknown. rs2 is used by ARITHMETIC, STORE and BRANCH. ECALL implicitly reads x17.
- Load-use hazard: ex_ctrl.mem_read && ex_valid && ex_rd!=0 && an used source of ID equals ex_rd.
- Ecall hazard: ID is ECALL and (EX stage has write_enable, ex_valid and ex_rd==17, or mem_write_enable and mem_rd==17).
- hazard = id_valid && (load-use || ecall hazard); stall = hazard && !flush.
- Register update priority: reset > flush > hazard > normal.
  - flush: load a bubble (ex_valid=0, ctrl all 0, alu_src_B=2'b11); data fields load normally (don't-care).
  - hazard: load a bubble.
  - normal: load all ID fields; ex_valid=id_valid. If id_valid=0, ctrl is loaded as a bubble.
- x0 never creates a hazard.
- Flush and hazard in the same cycle: a bubble is loaded and stall is low, so IF/ID refetches the new target.
- stall_count: +1 on each cycle stall=1. It saturates at 2^CNT_W-1 and clears only on reset.
- A reset in the middle of a stall clears everything; no hazard state persists.

Optional Feature:
FORWARDING_EN
- Defined: the block assumes EX/MEM and MEM/WB to EX forwarding exists. Data hazards are load-use only, plus the ecall rule.
- Undefined: the block stalls on any RAW in which an used ID source (nonzero) matches ex_rd (ex_valid and write_enable) or mem_rd (mem_write_enable). The register file is write-through, so WB needs no stall.
- Both modes share flush and counter behaviour.

Decomposition:
- Package pipe_pkg holds:
  - CTRL bit positions and CTRL_W=11.
  - BUBBLE_CTRL constant.
  - SrcB encodings.
  - ECALL_REG=17.
- Opcodes come from opcodes.v.
- Sub-module hazard_detect is purely combinational. It takes the ID indices/opcode and the EX/MEM rd info, and produces hazard. The FORWARDING_EN switch lives inside hazard_detect.

Test Plan:
- Reset: assert reset 2 cycles while id_valid=1 → all ex_* 0, alu_src_B=2'b11, stall_count=0.
- Load-use: lw x5 in EX, add x6,x5,x7 in ID → stall=1 for 1 cycle, bubble in EX, then add latched with ex_rd=6; stall_count=1.
- x0 load: lw x0 in EX, add x1,x0,x0 in ID → stall=0, add passes.
- Flush beats hazard: load-use condition plus flush=1 → stall=0, ex_valid=0, stall_count unchanged.
- Ecall: addi x17,x0,10 in EX, ecall in ID → stall=1. The following cycle, with x17 writer in MEM, stall stays 1 (mem_rd=17); then ecall latched with is_ecall=1.
- FORWARDING_EN off: add x3,.. in EX, sub x4,x3,x1 in ID → stall=1. With FORWARDING_EN on, the same stimulus gives stall=0.
